// File: rtl/collide_scan.sv
// Boundary-segment collision scanner: a runtime-writable segment table is walked one entry per
// cycle against a latched kid box. Define COLLIDE_HIT_IDX_EN to add the hit_idx output.
module collide_scan #(
    parameter int COORD_W = 10,
    parameter int SEG_NUM = 40,
    parameter int IDX_W   = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_addr,
    input  logic [3+3*COORD_W-1:0] wr_data,
    input  logic                   start,
    input  logic [COORD_W-1:0]     kid_t,
    input  logic [COORD_W-1:0]     kid_b,
    input  logic [COORD_W-1:0]     kid_l,
    input  logic [COORD_W-1:0]     kid_r,
    output logic                   busy,
    output logic                   done,
    output logic [3:0]             is_collide,
    output logic [1:0]             dbg_state
`ifdef COLLIDE_HIT_IDX_EN
    ,
    output logic [4*IDX_W-1:0]     hit_idx
`endif
);

    // start is a request with no ready: it is taken only in IDLE and otherwise dropped.
    // done is a one-cycle strobe; is_collide (and hit_idx) are valid from that cycle until the next one.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_DONE = 2'd2} state_t;

    typedef struct packed {
        logic               vld;
        logic [1:0]         dir;
        logic [COORD_W-1:0] lo;
        logic [COORD_W-1:0] hi;
        logic [COORD_W-1:0] pos;
    } seg_t;

    localparam logic [IDX_W:0]   SEG_NUM_L = (IDX_W+1)'(SEG_NUM);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SEG_NUM - 1);

    seg_t               tbl_q [SEG_NUM];
    seg_t               seg;
    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [3:0]         acc_q, acc_d;
    logic [3:0]         col_q, col_d;
    logic [3:0]         hit;
    logic [COORD_W-1:0] kt_q, kt_d, kb_q, kb_d, kl_q, kl_d, kr_q, kr_d;
    logic               span_h, span_v;
    logic               wr_ok;

    assign wr_ok = wr_en && ({1'b0, wr_addr} < SEG_NUM_L);

    // Only the valid bits need clearing; stale geometry behind vld=0 is harmless.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SEG_NUM; i++) tbl_q[i].vld <= 1'b0;
        end else if (wr_ok) begin
            tbl_q[wr_addr] <= seg_t'(wr_data);
        end
    end

    always_comb begin
        seg    = tbl_q[idx_q];
        span_h = (kl_q < seg.hi) && (kr_q > seg.lo);
        span_v = (kt_q < seg.hi) && (kb_q > seg.lo);
        hit    = 4'b0000;
        if (seg.vld && (seg.lo < seg.hi)) begin
            case (seg.dir)
                2'd0:    hit[3] = (kt_q == seg.pos) && span_h;
                2'd1:    hit[2] = (kb_q == seg.pos) && span_h;
                2'd2:    hit[1] = (kl_q == seg.pos) && span_v;
                default: hit[0] = (kr_q == seg.pos) && span_v;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        col_d   = col_q;
        kt_d    = kt_q;
        kb_d    = kb_q;
        kl_d    = kl_q;
        kr_d    = kr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
                    acc_d   = 4'b0000;
                    kt_d    = kid_t;
                    kb_d    = kid_b;
                    kl_d    = kid_l;
                    kr_d    = kid_r;
                end
            end
            S_SCAN: begin
                acc_d = acc_q | hit;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    col_d   = acc_q | hit;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            acc_q   <= 4'b0000;
            col_q   <= 4'b0000;
            kt_q    <= '0;
            kb_q    <= '0;
            kl_q    <= '0;
            kr_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            col_q   <= col_d;
            kt_q    <= kt_d;
            kb_q    <= kb_d;
            kl_q    <= kl_d;
            kr_q    <= kr_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign is_collide = col_q;
    assign dbg_state  = state_q;

`ifdef COLLIDE_HIT_IDX_EN
    logic [4*IDX_W-1:0] hacc_q, hacc_d, hidx_q, hidx_d;

    // A field is captured only on the first hit of its direction, giving the lowest index.
    always_comb begin
        hacc_d = hacc_q;
        hidx_d = hidx_q;
        if (state_q == S_IDLE && start) begin
            hacc_d = '1;
        end else if (state_q == S_SCAN) begin
            for (int d = 0; d < 4; d++) begin
                if (hit[d] && !acc_q[d]) hacc_d[d*IDX_W +: IDX_W] = idx_q;
            end
            if (idx_q == LAST_IDX) hidx_d = hacc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hacc_q <= '1;
            hidx_q <= '1;
        end else begin
            hacc_q <= hacc_d;
            hidx_q <= hidx_d;
        end
    end

    assign hit_idx = hidx_q;
`endif

endmodule

// File: tb/tb_collide_scan.sv
// Bench for collide_scan: directed scenarios with literal expectations plus randomized traffic,
// all checked every cycle against a write-log reference model.
module tb_collide_scan;

    localparam int COORD_W = 10;
    localparam int SEG_NUM = 40;
    localparam int IDX_W   = 6;
    localparam int WD      = 3 + 3*COORD_W;

    logic               clk = 1'b0;
    logic               rst;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_addr;
    logic [WD-1:0]      wr_data;
    logic               start;
    logic [COORD_W-1:0] kid_t, kid_b, kid_l, kid_r;
    logic               busy, done;
    logic [3:0]         is_collide;
    logic [1:0]         dbg_state;
`ifdef COLLIDE_HIT_IDX_EN
    logic [4*IDX_W-1:0] hit_idx;
`endif

    int n_checks = 0;
    int n_errors = 0;

    collide_scan #(.COORD_W(COORD_W), .SEG_NUM(SEG_NUM), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .kid_t      (kid_t),
        .kid_b      (kid_b),
        .kid_l      (kid_l),
        .kid_r      (kid_r),
        .busy       (busy),
        .done       (done),
        .is_collide (is_collide),
        .dbg_state  (dbg_state)
`ifdef COLLIDE_HIT_IDX_EN
        ,
        .hit_idx    (hit_idx)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Every accepted table write is logged with the number of the edge that commits it.
    // A scan accepted at edge N reads entry i as it stood after edge N+i.
    typedef struct {
        int            edge_no;
        int            addr;
        logic [WD-1:0] data;
    } wr_rec_t;

    wr_rec_t            log_q[$];
    int                 cyc       = 0;
    int                 scan_edge = -1;
    logic [COORD_W-1:0] m_t, m_b, m_l, m_r;
    logic [3:0]         exp_col   = 4'b0000;
    logic [4*IDX_W-1:0] exp_hidx  = '1;
    bit                 exp_busy  = 1'b0;
    bit                 exp_done  = 1'b0;
    bit                 chk_en    = 1'b0;

    function automatic void model_scan(input int n, output logic [3:0] col,
                                       output logic [4*IDX_W-1:0] hidx);
        logic [WD-1:0]      d;
        bit                 found;
        int                 dir;
        logic [COORD_W-1:0] lo, hi, pos, edge_v;
        bit                 span;
        col  = 4'b0000;
        hidx = '1;
        d    = '0;
        for (int i = 0; i < SEG_NUM; i++) begin
            found = 1'b0;
            foreach (log_q[k]) begin
                if (log_q[k].addr == i && log_q[k].edge_no <= n + i) begin
                    d     = log_q[k].data;
                    found = 1'b1;
                end
            end
            if (found && d[WD-1]) begin
                dir = int'(d[WD-2:WD-3]);
                lo  = d[3*COORD_W-1:2*COORD_W];
                hi  = d[2*COORD_W-1:COORD_W];
                pos = d[COORD_W-1:0];
                case (dir)
                    0:       begin edge_v = m_t; span = (m_l < hi) && (m_r > lo); end
                    1:       begin edge_v = m_b; span = (m_l < hi) && (m_r > lo); end
                    2:       begin edge_v = m_l; span = (m_t < hi) && (m_b > lo); end
                    default: begin edge_v = m_r; span = (m_t < hi) && (m_b > lo); end
                endcase
                if (lo < hi && span && edge_v == pos) begin
                    if (!col[3-dir]) hidx[(3-dir)*IDX_W +: IDX_W] = IDX_W'(i);
                    col[3-dir] = 1'b1;
                end
            end
        end
    endfunction

    always begin
        bit idle_before;
        @(posedge clk);
        cyc++;
        if (rst) begin
            log_q.delete();
            scan_edge = -1;
            exp_col   = 4'b0000;
            exp_hidx  = '1;
            chk_en    = 1'b1;
        end else begin
            idle_before = (scan_edge < 0);
            if (!idle_before && cyc == scan_edge + SEG_NUM) model_scan(scan_edge, exp_col, exp_hidx);
            if (!idle_before && cyc == scan_edge + SEG_NUM + 1) scan_edge = -1;
            if (idle_before && start) begin
                scan_edge = cyc;
                m_t = kid_t;
                m_b = kid_b;
                m_l = kid_l;
                m_r = kid_r;
            end
            if (wr_en && int'(wr_addr) < SEG_NUM) log_q.push_back('{cyc, int'(wr_addr), wr_data});
        end
        exp_busy = (scan_edge >= 0);
        exp_done = (scan_edge >= 0) && (cyc == scan_edge + SEG_NUM);
    end

    // ---------------- per-cycle compare ----------------
    always begin
        @(negedge clk);
        if (chk_en) begin
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            chk("is_collide", is_collide, exp_col);
`ifdef COLLIDE_HIT_IDX_EN
            chk("hit_idx", hit_idx, exp_hidx);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [COORD_W-1:0] rc();
        logic [COORD_W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = COORD_W'(1);
            2:       v = COORD_W'(2);
            3:       v = COORD_W'(3);
            4:       v = COORD_W'(5);
            5:       v = COORD_W'(8);
            6:       v = {COORD_W{1'b1}} - 1'b1;
            default: v = {COORD_W{1'b1}};
        endcase
        return v;
    endfunction

    task automatic wr(input int addr, input bit v, input int d, input int lo, input int hi, input int pos);
        wr_en   = 1'b1;
        wr_addr = IDX_W'(addr);
        wr_data = {v, 2'(d), COORD_W'(lo), COORD_W'(hi), COORD_W'(pos)};
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic scramble_kid();
        kid_t = rc();
        kid_b = rc();
        kid_l = rc();
        kid_r = rc();
    endtask

    // Counts cycles from the cycle start was high; pulses start again at cycle pulse_at if >0.
    task automatic wait_done(input int from, input int pulse_at, output int lat);
        lat = from;
        while (!done && lat < SEG_NUM + 20) begin
            start = (lat == pulse_at);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic scan(input int t, input int b, input int l, input int r, input int pulse_at,
                        input logic [3:0] lit, input string name);
        int lat;
        kid_t = COORD_W'(t);
        kid_b = COORD_W'(b);
        kid_l = COORD_W'(l);
        kid_r = COORD_W'(r);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble_kid();
        wait_done(1, pulse_at, lat);
        chk({name, "_latency"}, lat, SEG_NUM + 1);
        chk({name, "_result"}, is_collide, lit);
        chk({name, "_model"}, exp_col, lit);
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int lat;
        int n;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        kid_t   = '0;
        kid_b   = '0;
        kid_l   = '0;
        kid_r   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_collide", is_collide, 4'b0000);
`ifdef COLLIDE_HIT_IDX_EN
        chk("reset_hit_idx", hit_idx, {4*IDX_W{1'b1}});
`endif

        // empty table
        scan(100, 120, 50, 70, 0, 4'b0000, "empty");
        @(negedge clk);

        // single bottom entry at index 3
        wr(3, 1'b1, 1, 28, 125, 120);
        scan(100, 120, 50, 70, 0, 4'b0100, "bottom3");
`ifdef COLLIDE_HIT_IDX_EN
        chk("bottom3_hit_idx", hit_idx, {6'h3f, 6'd3, 6'h3f, 6'h3f});
`endif
        @(negedge clk);

        // strict span edges
        wr(3, 1'b1, 1, 70, 125, 120);
        scan(100, 120, 50, 70, 0, 4'b0000, "edge_r70");
        @(negedge clk);
        scan(100, 120, 50, 71, 0, 4'b0100, "edge_r71");
        @(negedge clk);

        // one entry per direction, extra start during the scan is dropped
        pulse_rst();
        wr(0, 1'b1, 0, 50, 90, 416);
        wr(1, 1'b1, 1, 50, 90, 448);
        wr(2, 1'b1, 2, 400, 460, 60);
        wr(3, 1'b1, 3, 400, 460, 80);
        scan(416, 448, 60, 80, 10, 4'b1111, "all4");
`ifdef COLLIDE_HIT_IDX_EN
        chk("all4_hit_idx", hit_idx, {6'd0, 6'd1, 6'd2, 6'd3});
`endif
        count_dones(SEG_NUM + 5, n);
        chk("all4_single_done", n, 0);

        // writes during a scan
        pulse_rst();
        kid_t = 10'd100;
        kid_b = 10'd120;
        kid_l = 10'd50;
        kid_r = 10'd70;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        wr(10, 1'b1, 0, 28, 125, 100);
        wr(2, 1'b1, 2, 90, 130, 50);
        wr(SEG_NUM, 1'b1, 3, 90, 130, 70);
        wait_done(12, 0, lat);
        chk("midscan_latency", lat, SEG_NUM + 1);
        chk("midscan_result", is_collide, 4'b1000);
        chk("midscan_model", exp_col, 4'b1000);
        @(negedge clk);
        scan(100, 120, 50, 70, 0, 4'b1010, "next_scan");
`ifdef COLLIDE_HIT_IDX_EN
        chk("next_scan_hit_idx", hit_idx, {6'd10, 6'h3f, 6'd2, 6'h3f});
`endif
        @(negedge clk);

        // reset in the middle of a scan
        kid_t = 10'd100;
        kid_b = 10'd120;
        kid_l = 10'd50;
        kid_r = 10'd70;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        pulse_rst();
        chk("abort_busy", busy, 1'b0);
        chk("abort_collide", is_collide, 4'b0000);
        count_dones(SEG_NUM + 5, n);
        chk("abort_no_done", n, 0);
        scan(100, 120, 50, 70, 0, 4'b0000, "after_abort");
        @(negedge clk);

        // randomized traffic
        for (int c = 0; c < 6000; c++) begin
            rst     = ($urandom_range(0, 999) == 0);
            wr_en   = ($urandom_range(0, 99) < 40);
            wr_addr = IDX_W'($urandom_range(0, SEG_NUM + 3));
            wr_data = {1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), rc(), rc(), rc()};
            start   = ($urandom_range(0, 9) == 0);
            scramble_kid();
            @(negedge clk);
        end
        rst   = 1'b0;
        wr_en = 1'b0;
        start = 1'b0;
        repeat (SEG_NUM + 5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/collide_scan.md
Name: collide_scan

Overview:
- Parametrised successor to the fixed-table kid collision detector.
- Holds a runtime-writable table of axis-aligned boundary segments, so a room change rewrites the table instead of resynthesising.
- On a start request it scans one segment per cycle against the latched kid bounding box.
- Returns 4-bit top/bottom/left/right collision flags with a done pulse; sits between the kid motion logic and the room loader.

Parameters:
- COORD_W, 10, width of every screen coordinate
- SEG_NUM, 40, number of table entries (must be ≥1)
- IDX_W, 6, table address width; SEG_NUM ≤ 2**IDX_W

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  table write strobe
- wr_addr  input  IDX_W  table entry to write
- wr_data  input  3+3*COORD_W  {vld, dir[1:0], lo, hi, pos}; dir 0=top, 1=bottom, 2=left, 3=right
- start  input  1  request a scan; sampled only in IDLE
- kid_t, kid_b, kid_l, kid_r  input  COORD_W each  kid box edges, latched on accepted start
- busy  output  1  high in SCAN and DONE
- done  output  1  one-cycle pulse when is_collide is updated
- is_collide  output  4  [3]=top [2]=bottom [1]=left [0]=right

Behaviour:
- Reset: all table vld bits = 0, state = IDLE, busy = 0, done = 0, is_collide = 4'b0000, internal accumulator = 0. Reset aborts any scan; no done pulse is issued.
- Table write: on wr_en, the entry at wr_addr is replaced at the clock edge. Writes with wr_addr ≥ SEG_NUM are dropped. Writes are accepted in every state.
- Scan reads use registered table contents, i.e. contents before that cycle's write.
- Match rules, all unsigned and strict; entry counts only if vld=1:
  - top: kid_t==pos and kid_l<hi and kid_r>lo
  - bottom: kid_b==pos and kid_l<hi and kid_r>lo
  - left: kid_l==pos and kid_t<hi and kid_b>lo
  - right: kid_r==pos and kid_t<hi and kid_b>lo
- A matching entry ORs into accumulator bit (3-dir).
- FSM states:
  - IDLE: on start=1, latch the kid edges, clear the accumulator, idx=0, go to SCAN. A start in any other state is ignored, not queued.
  - SCAN: evaluate entry idx each cycle. If idx==SEG_NUM-1, go to DONE; else idx+1.
  - DONE: is_collide <= accumulator OR that cycle's match, done=1 for this cycle, go to IDLE.
- Latency: start accepted at edge N → done high and is_collide valid in cycle N+SEG_NUM+1. A back-to-back start is accepted the cycle after done.
- is_collide holds its value between done pulses and is unaffected by writes or by kid input changes during a scan.
- A write to an entry not yet reached affects the current scan. A write to an entry already passed affects the next scan only.
- Boundary cases:
  - pos==0 and pos==2**COORD_W-1 compare normally; there is no wrap.
  - A zero-length segment (lo ≥ hi) can never match.

Optional Feature:
- Macro COLLIDE_HIT_IDX_EN.
- Defined: adds output hit_idx, 4*IDX_W wide, one IDX_W field per direction in the same bit order as is_collide. Each field holds the lowest-index matching entry for that direction, or all-ones if none matched. It updates together with is_collide on done and resets to all-ones.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Reset, then start with kid box (t=100, b=120, l=50, r=70) and an empty table → done exactly SEG_NUM+1 cycles later, is_collide=0000.
- Write entry 3 = {1, bottom, lo=28, hi=125, pos=120}, start with kid (t=100, b=120, l=50, r=70) → is_collide=0100; with COLLIDE_HIT_IDX_EN, bottom field=3 and the other fields all-ones.
- Edge strictness: bottom entry lo=70, hi=125, pos=120 with kid r=70 → 0000; kid r=71 → 0100.
- Four entries (one per direction) all matching kid (t=416, b=448, l=60, r=80): top pos=416, bottom pos=448, left pos=60, right pos=80 → 1111. Pulse start during the scan → ignored, exactly one done.
- Mid-scan writes: during a scan, write a matching entry at idx+2 → detected this scan. Write one at an already-passed index → not detected now, detected on the next scan. Write to wr_addr=SEG_NUM → no effect.
- Assert rst at scan cycle 5 → no done, busy=0 next cycle, is_collide=0000, table invalidated; the following scan returns 0000.
